// File: rtl/slt_pipe_unit_pkg.sv
// Shared constants for the set-on-less-than datapath: R-type funct codes,
// default widths and the funct -> signedness decode.
package slt_pkg;

  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam int SLT_WIDTH = 32;
  localparam int SLT_TAG_W = 5;

  function automatic logic funct_is_signed(input logic [5:0] funct);
    return funct == FUNCT_SLT;
  endfunction

  function automatic logic funct_is_slt(input logic [5:0] funct);
    return (funct == FUNCT_SLT) || (funct == FUNCT_SLTU);
  endfunction

endpackage

// File: rtl/slt_pipe_unit_if.sv
// Operand/result handshake bundle between register-read, the slt unit and writeback.
interface slt_pipe_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_eq;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op_a, op_b, op_signed, in_tag, out_ready,
    input  in_ready, out_valid, result, out_eq, out_tag
  );

  modport slave (
    input  in_valid, op_a, op_b, op_signed, in_tag, out_ready,
    output in_ready, out_valid, result, out_eq, out_tag
  );
endinterface

// File: rtl/slt_pipe_unit_flag_zext.sv
// Zero-extends a single-bit flag to a full datapath word; shared by all
// flag-producing ALU ops.
module flag_zext #(
  parameter int WIDTH = 32
) (
  input  logic             flag_i,
  output logic [WIDTH-1:0] vec_o
);
  assign vec_o = {{(WIDTH-1){1'b0}}, flag_i};
endmodule

// File: rtl/slt_pipe_unit.sv
// Two-stage slt/sltu unit: stage 1 forms the WIDTH+1 bit difference, stage 2
// extracts lt/eq; valid/ready backpressure, flush and a saturating lt counter.
module slt_pipe_unit
  import slt_pkg::*;
#(
  parameter int WIDTH   = SLT_WIDTH,
  parameter int TAG_W   = SLT_TAG_W,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  slt_pipe_unit_if.slave     bus,
  output logic [COUNT_W-1:0] lt_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH:0]     s1_diff_q,  s1_diff_d;
  logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
  logic               s2_valid_q, s2_valid_d;
  logic               s2_lt_q,    s2_lt_d;
  logic               s2_eq_q,    s2_eq_d;
  logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;
  logic [COUNT_W-1:0] cnt_q,      cnt_d;

  logic s1_en, s2_en, accept, deliver;
  logic [WIDTH:0] ext_a, ext_b;

  assign s2_en   = !s2_valid_q || bus.out_ready;
  assign s1_en   = !s1_valid_q || s2_en;
  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = s2_valid_q && bus.out_ready;

  assign bus.in_ready = s1_en && !flush;

  // One extra bit makes the subtraction exact for both signed and unsigned operands.
  assign ext_a = {bus.op_signed & bus.op_a[WIDTH-1], bus.op_a};
  assign ext_b = {bus.op_signed & bus.op_b[WIDTH-1], bus.op_b};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_lt_d    = s2_lt_q;
    s2_eq_d    = s2_eq_q;
    s2_tag_d   = s2_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_diff_d = ext_a - ext_b;
          s1_tag_d  = bus.in_tag;
        end
      end
      if (s2_en) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_lt_d  = s1_diff_q[WIDTH];
          // An exact difference is zero exactly when the operands match bitwise.
          s2_eq_d  = (s1_diff_q == '0);
          s2_tag_d = s1_tag_q;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver && s2_lt_q && (cnt_q != {COUNT_W{1'b1}}))
      cnt_d = cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_lt_q    <= 1'b0;
      s2_eq_q    <= 1'b0;
      s2_tag_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_lt_q    <= s2_lt_d;
      s2_eq_q    <= s2_eq_d;
      s2_tag_q   <= s2_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_eq    = s2_eq_q;
  assign bus.out_tag   = s2_tag_q;
  assign lt_count      = cnt_q;

  flag_zext #(.WIDTH(WIDTH)) u_zext (
    .flag_i (s2_lt_q),
    .vec_o  (bus.result)
  );

endmodule

// File: tb/tb_slt_pipe_unit.sv
// Directed bench for slt_pipe_unit: latency, boundary compares, streaming,
// backpressure, flush, counter saturation and mid-stream reset.
module tb_slt_pipe_unit;
  import slt_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [CW-1:0] lt_count;

  slt_pipe_unit_if #(.WIDTH(W), .TAG_W(TW)) bus();

  slt_pipe_unit #(.WIDTH(W), .TAG_W(TW), .COUNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .lt_count (lt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0]  q_res[$];
  logic          q_eq[$];
  logic [TW-1:0] q_tag[$];
  int            q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Deliveries are logged mid-cycle, when handshake signals are stable.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      q_res.push_back(bus.result);
      q_eq.push_back(bus.out_eq);
      q_tag.push_back(bus.out_tag);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [TW-1:0] t);
    bus.in_valid  = v;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_signed = s;
    bus.in_tag    = t;
    #1;
  endtask

  task automatic clear_q();
    q_res.delete(); q_eq.delete(); q_tag.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, '0, '0, 0, '0);
    step();
    step();
    reset = 1'b0;
    clear_q();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.out_eq !== 1'b0) begin n_fail++; $display("FAIL reset_out_eq: got %0b want 0", bus.out_eq); end
    n_checks++; if (bus.out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); end
    n_checks++; if (lt_count !== '0) begin n_fail++; $display("FAIL reset_lt_count: got %0d want 0", lt_count); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 32'd5, 32'd7, funct_is_signed(FUNCT_SLT), 5'd3);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0b want 1", bus.in_ready); end
    step();
    drive(0, '0, '0, 0, '0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %0b want 0", bus.out_valid); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL basic_result: got %h want 00000001", bus.result); end
    n_checks++; if (bus.out_eq !== 1'b0) begin n_fail++; $display("FAIL basic_eq: got %0b want 0", bus.out_eq); end
    n_checks++; if (bus.out_tag !== 5'd3) begin n_fail++; $display("FAIL basic_tag: got %0d want 3", bus.out_tag); end
    n_checks++; if (lt_count !== 2'd0) begin n_fail++; $display("FAIL basic_count_pre: got %0d want 0", lt_count); end
    step();
    n_checks++; if (lt_count !== 2'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", lt_count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [8] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00001234};
    logic [W-1:0] tb [8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h0,
                             32'h0, 32'h80000000, 32'h80000000, 32'h00001234};
    logic [7:0] ts  = 8'b0010_1101;
    logic [7:0] tlt = 8'b0100_1001;
    logic [7:0] teq = 8'b1000_0100;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, ta[i], tb[i], ts[i], TW'(i));
      step();
    end
    drive(0, '0, '0, 0, '0);
    repeat (3) step();
    n_checks++; if (q_res.size() !== 8) begin n_fail++; $display("FAIL bound_count: got %0d results want 8", q_res.size()); end
    for (int i = 0; i < 8 && i < q_res.size(); i++) begin
      n_checks++; if (q_res[i] !== {31'b0, tlt[i]}) begin n_fail++; $display("FAIL bound_result[%0d]: got %h want %0d", i, q_res[i], tlt[i]); end
      n_checks++; if (q_eq[i] !== teq[i]) begin n_fail++; $display("FAIL bound_eq[%0d]: got %0b want %0b", i, q_eq[i], teq[i]); end
      n_checks++; if (q_tag[i] !== TW'(i)) begin n_fail++; $display("FAIL bound_tag[%0d]: got %0d want %0d", i, q_tag[i], i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [8] = '{32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF,
                             32'h0, 32'h1, 32'h2, 32'h3};
    logic [7:0] tlt = 8'b0000_0011;
    logic [7:0] teq = 8'b0000_0100;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, ta[i], 32'hFFFFFFFE, 1'b1, TW'(i + 8));
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, bus.in_ready); end
      step();
    end
    drive(0, '0, '0, 0, '0);
    repeat (3) step();
    n_checks++; if (q_res.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", q_res.size()); end
    for (int i = 0; i < 8 && i < q_res.size(); i++) begin
      n_checks++; if (q_res[i] !== {31'b0, tlt[i]}) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %0d", i, q_res[i], tlt[i]); end
      n_checks++; if (q_eq[i] !== teq[i]) begin n_fail++; $display("FAIL b2b_eq[%0d]: got %0b want %0b", i, q_eq[i], teq[i]); end
      n_checks++; if (q_tag[i] !== TW'(i + 8)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, q_tag[i], i + 8); end
      n_checks++; if (q_cyc[i] !== q_cyc[0] + i) begin n_fail++; $display("FAIL b2b_consecutive[%0d]: got cycle %0d want %0d", i, q_cyc[i], q_cyc[0] + i); end
    end
    n_checks++; if (lt_count !== 2'd2) begin n_fail++; $display("FAIL b2b_lt_count: got %0d want 2", lt_count); end
  endtask

  task automatic test_stall();
    logic [5:0] tlt = 6'b00_0111;
    logic [5:0] teq = 6'b00_1000;
    int k = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus.out_ready = (c >= 6);
      if (k < 6) drive(1, W'(k), 32'd3, 1'b0, TW'(16 + k));
      else       drive(0, '0, '0, 0, '0);
      if (c == 2) begin
        n_checks++; if (k !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d want 2", k); end
      end
      if (c >= 2 && c < 6) begin
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[c%0d]: got %0b want 0", c, bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[c%0d]: got %0b want 1", c, bus.out_valid); end
        n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL stall_result[c%0d]: got %h want 1", c, bus.result); end
        n_checks++; if (bus.out_tag !== 5'd16) begin n_fail++; $display("FAIL stall_tag[c%0d]: got %0d want 16", c, bus.out_tag); end
      end
      if (k < 6 && bus.in_ready) k++;
      step();
    end
    n_checks++; if (q_res.size() !== 6) begin n_fail++; $display("FAIL stall_count: got %0d results want 6", q_res.size()); end
    for (int i = 0; i < 6 && i < q_res.size(); i++) begin
      n_checks++; if (q_tag[i] !== TW'(16 + i)) begin n_fail++; $display("FAIL stall_order[%0d]: got tag %0d want %0d", i, q_tag[i], 16 + i); end
      n_checks++; if (q_res[i] !== {31'b0, tlt[i]}) begin n_fail++; $display("FAIL stall_res[%0d]: got %h want %0d", i, q_res[i], tlt[i]); end
      n_checks++; if (q_eq[i] !== teq[i]) begin n_fail++; $display("FAIL stall_eq[%0d]: got %0b want %0b", i, q_eq[i], teq[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    drive(1, 32'd0, 32'd1, 1'b0, 5'd1);
    step();
    drive(1, 32'd2, 32'd9, 1'b0, 5'd2);
    step();
    flush = 1'b1;
    drive(1, 32'd3, 32'd9, 1'b0, 5'd3);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: got %0b want 1", bus.out_valid); end
    step();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, '0, '0, 0, '0);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid[c%0d]: got %0b want 0", c, bus.out_valid); end
      step();
    end
    n_checks++; if (q_res.size() !== 0) begin n_fail++; $display("FAIL flush_leak: got %0d results want 0", q_res.size()); end
    n_checks++; if (lt_count !== 2'd0) begin n_fail++; $display("FAIL flush_lt_count: got %0d want 0", lt_count); end
    // Flush coinciding with an accepted delivery still counts that delivery.
    drive(1, 32'd0, 32'd1, 1'b0, 5'd4);
    step();
    drive(0, '0, '0, 0, '0);
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_deliver_valid: got %0b want 1", bus.out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (lt_count !== 2'd1) begin n_fail++; $display("FAIL flush_deliver_count: got %0d want 1", lt_count); end
    n_checks++; if (q_res.size() !== 1) begin n_fail++; $display("FAIL flush_deliver_log: got %0d results want 1", q_res.size()); end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'd0, 32'd1, 1'b0, TW'(i));
      step();
    end
    drive(0, '0, '0, 0, '0);
    repeat (3) step();
    n_checks++; if (q_res.size() !== 5) begin n_fail++; $display("FAIL sat_deliveries: got %0d want 5", q_res.size()); end
    n_checks++; if (lt_count !== 2'd3) begin n_fail++; $display("FAIL sat_lt_count: got %0d want 3", lt_count); end
    drive(1, 32'd0, 32'd1, 1'b0, 5'd9);
    step();
    drive(1, 32'd4, 32'd4, 1'b0, 5'd10);
    step();
    n_checks++; if (bus.result !== 32'h1 || bus.out_tag !== 5'd9) begin n_fail++; $display("FAIL rst_pre: got result %h tag %0d want 1 tag 9", bus.result, bus.out_tag); end
    reset = 1'b1;
    drive(1, 32'd6, 32'd7, 1'b0, 5'd11);
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL rst_result: got %h want 0", bus.result); end
    n_checks++; if (bus.out_eq !== 1'b0) begin n_fail++; $display("FAIL rst_eq: got %0b want 0", bus.out_eq); end
    n_checks++; if (bus.out_tag !== '0) begin n_fail++; $display("FAIL rst_tag: got %0d want 0", bus.out_tag); end
    n_checks++; if (lt_count !== '0) begin n_fail++; $display("FAIL rst_lt_count: got %0d want 0", lt_count); end
    reset = 1'b0;
    drive(0, '0, '0, 0, '0);
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
